// File: rtl/t_gen_collect_if.sv
// Output handshake of the event collector: granted lane index on valid/ready.
interface t_gen_collect_if #(
  parameter int unsigned IDX_W = 2
) ();
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);
endinterface

// File: rtl/t_gen_collect.sv
// Mask-filtered event collector: enabled lanes latch event pulses into pending bits,
// which a round-robin scheduler drains as lane indices on a registered valid/ready output.
module t_gen_collect #(
  parameter int unsigned     MAX_SIZE = 4,
  parameter int unsigned     SIZE     = 4,
  parameter logic [SIZE-1:0] MASK     = '0,
  parameter int unsigned     IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAX_SIZE-1:0] req,
  t_gen_collect_if.master     out,
  output logic [MAX_SIZE-1:0] pending,
  output logic [7:0]          drop_cnt
);

  // Zero-extended copy so lane enables never select MASK past SIZE-1.
  localparam logic [MAX_SIZE-1:0] MaskExt = MAX_SIZE'(MASK);

  logic [IDX_W-1:0]    ptr;
  logic                load;
  logic                found;
  logic                found_lo;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    cand_lo;
  logic [IDX_W-1:0]    ptr_next;
  logic [MAX_SIZE-1:0] clr;
  logic [MAX_SIZE-1:0] drop;
  logic [MAX_SIZE-1:0] en;
  logic                unused_req;

  assign load = !out.out_valid || out.out_ready;

  // First pending lane at or after ptr wins; otherwise the lowest pending lane (wrap at SIZE).
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    found_lo = 1'b0;
    cand_lo  = '0;
    for (int k = 0; k < int'(SIZE); k++) begin
      if (pending[k] && !found && (IDX_W'(k) >= ptr)) begin
        found = 1'b1;
        cand  = IDX_W'(k);
      end
      if (pending[k] && !found_lo) begin
        found_lo = 1'b1;
        cand_lo  = IDX_W'(k);
      end
    end
    if (!found) begin
      found = found_lo;
      cand  = cand_lo;
    end
  end

  assign ptr_next = (cand == IDX_W'(SIZE - 1)) ? '0 : cand + IDX_W'(1);
  assign clr      = (load && found) ? (MAX_SIZE'(1) << cand) : '0;

  for (genvar g = 0; g < MAX_SIZE; g++) begin : g_lane
    if ((g < SIZE) && MaskExt[g]) begin : g_on
      logic pend_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_q <= 1'b0;
        end else begin
          pend_q <= req[g] | (pend_q & ~clr[g]);
        end
      end
      assign pending[g] = pend_q;
      assign drop[g]    = req[g] & pend_q & ~clr[g];
      assign en[g]      = 1'b1;
    end else begin : g_off
      assign pending[g] = 1'b0;
      assign drop[g]    = 1'b0;
      assign en[g]      = 1'b0;
    end
  end

  assign unused_req = ^(req & ~en);

  always_ff @(posedge clk) begin
    if (rst) begin
      out.out_valid <= 1'b0;
      out.out_idx   <= '0;
      ptr           <= '0;
      drop_cnt      <= 8'd0;
    end else begin
      if (load) begin
        out.out_valid <= found;
        if (found) begin
          out.out_idx <= cand;
          ptr         <= ptr_next;
        end
      end
      // Simultaneous drops on several lanes count once.
      if (|drop && (drop_cnt != 8'hff)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
